// File: rtl/goertzel_state_bank.sv
// rtl/goertzel_state_bank.sv - per-channel Goertzel S1/S2 state storage with bank clear FSM
// Optional macro GOERTZEL_STATE_BANK_BYPASS_EN: same-cycle write-to-read forwarding.
module goertzel_state_bank #(
    parameter int N  = 61,
    parameter int C  = 4,
    parameter int CW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic signed [N-1:0] x,
    output logic                wr_drop,
    input  logic                rd_en,
    input  logic [CW-1:0]       rd_ch,
    output logic signed [N-1:0] y1,
    output logic signed [N-1:0] y2,
    output logic                rd_valid
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [CW-1:0]       cc;
    logic signed [N-1:0] s1 [C];
    logic signed [N-1:0] s2 [C];

    logic [31:0]         wr_idx;
    logic [31:0]         rd_idx;
    logic [31:0]         cc_idx;
    logic                wr_ok;
    logic signed [N-1:0] rd_s1;
    logic signed [N-1:0] rd_s2;
    logic signed [N-1:0] nxt_y1;
    logic signed [N-1:0] nxt_y2;

    // Indices widened so range checks against C stay meaningful for any CW.
    assign wr_idx = 32'(wr_ch);
    assign rd_idx = 32'(rd_ch);
    assign cc_idx = 32'(cc);
    assign wr_ok  = wr_en && !busy && (wr_idx < 32'(C));

    always_comb begin
        rd_s1 = '0;
        rd_s2 = '0;
        for (int i = 0; i < C; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_s1 = s1[i];
                rd_s2 = s2[i];
            end
        end
        nxt_y1 = rd_s1;
        nxt_y2 = rd_s2;
`ifdef GOERTZEL_STATE_BANK_BYPASS_EN
        if (wr_ok && (wr_ch == rd_ch)) begin
            nxt_y1 = x;
            nxt_y2 = rd_s1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cc       <= '0;
            busy     <= 1'b0;
            wr_drop  <= 1'b0;
            rd_valid <= 1'b0;
            y1       <= '0;
            y2       <= '0;
            for (int i = 0; i < C; i++) begin
                s1[i] <= '0;
                s2[i] <= '0;
            end
        end else begin
            wr_drop  <= wr_en && !wr_ok;
            rd_valid <= rd_en;
            if (rd_en) begin
                y1 <= nxt_y1;
                y2 <= nxt_y2;
            end

            // Clear step wins over a write to the same channel.
            for (int i = 0; i < C; i++) begin
                if (state == CLEAR && cc_idx == 32'(i)) begin
                    s1[i] <= '0;
                    s2[i] <= '0;
                end else if (wr_ok && wr_idx == 32'(i)) begin
                    s2[i] <= s1[i];
                    s1[i] <= x;
                end
            end

            case (state)
                IDLE: begin
                    if (clr) begin
                        cc    <= '0;
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cc <= cc + 1'b1;
                    if (cc_idx == 32'(C - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goertzel_state_bank.sv
// tb/tb_goertzel_state_bank.sv - scoreboard bench for goertzel_state_bank
module tb_goertzel_state_bank;
    localparam int N  = 61;
    localparam int C  = 4;
    localparam int CW = 3;

    logic                clk = 1'b0;
    logic                rst, clr, wr_en, rd_en;
    logic [CW-1:0]       wr_ch, rd_ch;
    logic signed [N-1:0] x;
    logic                busy, wr_drop, rd_valid;
    logic signed [N-1:0] y1, y2;

    int total = 0;
    int bad   = 0;

    logic signed [N-1:0] exp_y1_q [$];
    logic signed [N-1:0] exp_y2_q [$];

    goertzel_state_bank #(.N(N), .C(C), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .wr_en(wr_en), .wr_ch(wr_ch), .x(x), .wr_drop(wr_drop),
        .rd_en(rd_en), .rd_ch(rd_ch), .y1(y1), .y2(y2), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [N-1:0] act, input logic signed [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic signed [N-1:0] e1, input logic signed [N-1:0] e2);
        exp_y1_q.push_back(e1);
        exp_y2_q.push_back(e2);
    endtask

    task automatic do_write(input int ch, input logic signed [N-1:0] v);
        wr_en = 1'b1; wr_ch = CW'(ch); x = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int ch, input logic signed [N-1:0] e1, input logic signed [N-1:0] e2);
        rd_en = 1'b1; rd_ch = CW'(ch);
        expect_rd(e1, e2);
        tick();
        rd_en = 1'b0;
    endtask

    // Monitor: every rd_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_y1_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_valid: got y1=%0d y2=%0d expected no read", y1, y2);
            end else begin
                chk("rd_y1", y1, exp_y1_q.pop_front());
                chk("rd_y2", y2, exp_y2_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [N-1:0] big_neg;
        logic signed [N-1:0] big_pos;
        big_neg = {1'b1, {(N-1){1'b0}}};
        big_pos = {1'b0, {(N-1){1'b1}}};

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_ch = '0; rd_ch = '0; x = '0;
        tick(); tick();
        chk("rst_busy", N'(busy), 0);
        chk("rst_wr_drop", N'(wr_drop), 0);
        chk("rst_rd_valid", N'(rd_valid), 0);
        chk("rst_y1", y1, 0);
        chk("rst_y2", y2, 0);
        rst = 1'b0;

        // Shift of two samples into ch1, others untouched.
        do_write(1, 5);
        do_write(1, -3);
        do_read(0, 0, 0);
        do_read(2, 0, 0);
        do_read(3, 0, 0);
        do_read(5, 0, 0);
        do_read(1, -3, 5);
        tick();
        chk("hold_rd_valid", N'(rd_valid), 0);
        chk("hold_y1", y1, -3);
        chk("hold_y2", y2, 5);

        // Full-width values stored without modification.
        do_write(2, big_neg);
        do_write(2, big_pos);
        do_read(2, big_pos, big_neg);

        // Same-cycle write and read on ch0 holding S1=1, S2=2.
        do_write(0, 2);
        do_write(0, 1);
        wr_en = 1'b1; wr_ch = 0; x = 7;
        rd_en = 1'b1; rd_ch = 0;
`ifdef GOERTZEL_STATE_BANK_BYPASS_EN
        expect_rd(7, 1);
`else
        expect_rd(1, 2);
`endif
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        do_read(0, 7, 1);

        // Bank clear: busy for exactly C cycles, second clr ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy0", N'(busy), 1);
        clr = 1'b1;
        rd_en = 1'b1; rd_ch = 1;
        expect_rd(-3, 5);
        tick();
        clr = 1'b0; rd_en = 1'b0;
        chk("clr_busy1", N'(busy), 1);
        wr_en = 1'b1; wr_ch = 2; x = 99;
        tick();
        wr_en = 1'b0;
        chk("clr_busy2", N'(busy), 1);
        chk("busy_drop_set", N'(wr_drop), 1);
        tick();
        chk("clr_busy3", N'(busy), 1);
        chk("busy_drop_clear", N'(wr_drop), 0);
        tick();
        chk("clr_busy_end", N'(busy), 0);
        tick();
        chk("clr_busy_not_extended", N'(busy), 0);
        for (int i = 0; i < C; i++) do_read(i, 0, 0);

        // Out-of-range write is dropped and touches nothing.
        do_write(1, 8);
        do_write(5, 123);
        chk("range_drop_set", N'(wr_drop), 1);
        tick();
        chk("range_drop_clear", N'(wr_drop), 0);
        do_read(1, 8, 0);
        do_read(5, 0, 0);

        // Reset in the middle of a clear aborts it.
        do_write(3, 11);
        do_read(3, 11, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        rst = 1'b1; rd_en = 1'b1; rd_ch = 3;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        chk("abort_busy", N'(busy), 0);
        chk("abort_y1", y1, 0);
        chk("abort_y2", y2, 0);
        chk("abort_rd_valid", N'(rd_valid), 0);
        tick();
        chk("abort_busy_after", N'(busy), 0);
        do_write(3, 42);
        chk("post_abort_no_drop", N'(wr_drop), 0);
        do_read(3, 42, 0);
        do_read(1, 0, 0);
        tick();
        tick();

        chk("scoreboard_drained", N'(exp_y1_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/goertzel_state_bank.md
GOERTZEL_STATE_BANK -- requirements
Module: goertzel_state_bank

Interface
REQ-001 Parameters SHALL be:
  - N, default 61, data width in bits (signed).
  - C, default 4, channel count (C >= 2).
  - CW, default 2, channel index width (2^CW >= C).
REQ-002 Ports SHALL be:
  - clk  in  1  clock
  - rst  in  1  reset
  - clr  in  1  start whole-bank clear
  - busy  out  1  clear sequence in progress
  - wr_en  in  1  write request
  - wr_ch  in  CW  write channel index
  - x  in  N signed  new state value s[n]
  - wr_drop  out  1  write request discarded
  - rd_en  in  1  read request
  - rd_ch  in  CW  read channel index
  - y1  out  N signed  s[n-1] of read channel
  - y2  out  N signed  s[n-2] of read channel
  - rd_valid  out  1  y1/y2 valid
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high on rst.

Function
REQ-004 Per channel c, the block SHALL hold two signed N-bit registers, S1[c] and S2[c].
REQ-005 An accepted write SHALL update both registers in one clk edge: S2[wr_ch] <= S1[wr_ch] and S1[wr_ch] <= x.
REQ-006 A write SHALL be accepted only when wr_en=1, busy=0 and wr_ch < C.
REQ-007 When wr_en=1 and the write is not accepted, the block SHALL leave all state unchanged and assert wr_drop=1 for exactly the next cycle.
REQ-008 A read SHALL have 1-cycle latency: when rd_en=1 at edge k, y1/y2 SHALL present S1[rd_ch]/S2[rd_ch] after edge k+1, with rd_valid=1 for that one cycle.
REQ-009 When rd_en=0, y1 and y2 SHALL hold their last values and rd_valid SHALL be 0.
REQ-010 A read with rd_ch >= C SHALL return y1=y2=0 with rd_valid=1.
REQ-011 Reads SHALL be accepted while busy=1 and SHALL return the current register contents.
REQ-012 The clear FSM SHALL have two states, IDLE and CLEAR, driven by a clear counter cc (CW bits).
REQ-013 In IDLE, clr=1 SHALL set cc=0 and move the FSM to CLEAR.
REQ-014 In CLEAR, each cycle SHALL zero S1[cc] and S2[cc] and then increment cc.
REQ-015 When CLEAR processes cc=C-1, the FSM SHALL return to IDLE.
REQ-016 The clear sequence SHALL take exactly C cycles.
REQ-017 busy SHALL equal 1 exactly while the FSM is in CLEAR.
REQ-018 clr asserted while busy=1 SHALL be ignored and SHALL NOT restart the sequence.
REQ-019 A write rejected because busy=1 SHALL NOT corrupt any channel.
REQ-020 If a write and a clear step target the same channel in the same cycle, the clear SHALL take effect.
REQ-021 All arithmetic SHALL be pure storage: no truncation, extension or saturation of x.

Reset
REQ-022 When rst=1 at a clk edge, S1[*] and S2[*] SHALL be 0, y1=y2=0, rd_valid=0, wr_drop=0, busy=0, FSM=IDLE and cc=0.
REQ-023 rst SHALL take priority over clr, wr_en and rd_en.
REQ-024 rst asserted mid-clear SHALL abort the sequence and leave the FSM in IDLE.

Configuration
REQ-025 Macro GOERTZEL_STATE_BANK_BYPASS_EN SHALL control read/write forwarding.
REQ-026 With the macro defined, a read and an accepted write to the same channel in the same cycle SHALL return the post-write values: y1=x and y2=old S1.
REQ-027 Without the macro, the same same-cycle read and write SHALL return the pre-write values: y1=old S1 and y2=old S2.

Verification
REQ-028 After reset, write ch1 x=5, then x=-3, then read ch1 -> next cycle y1=-3, y2=5, rd_valid=1; all other channels read 0.
REQ-029 Pulse clr with C=4 -> busy=1 for exactly 4 cycles; all S1/S2 read 0 afterwards; a second clr during busy does not extend busy.
REQ-030 wr_en=1 with wr_ch=2 during busy, and wr_en=1 with wr_ch=5 (CW=3, C=4) -> wr_drop=1 for one cycle each; channel contents unchanged.
REQ-031 Same-cycle write x=7 and read on ch0 holding S1=1, S2=2 -> y1=7, y2=1 with the macro; y1=1, y2=2 without it.
REQ-032 Assert rst during cycle 2 of a clear -> busy=0 next cycle and all outputs 0; a subsequent write is accepted.
